// File: rtl/ipv4_ttl_decrement_pkg.sv
// Shared constants, beat-1 field offsets and FSM encoding for the IPv4 TTL decrement stage.
// Also provides the 16-bit one's-complement adder used by the checksum updater.
package ipv4_pkg;

   localparam logic [3:0] IPV4_VERSION = 4'd4;
   localparam logic [3:0] IPV4_IHL_MIN = 4'd5;

   localparam int TTL_MSB   = 63;
   localparam int PROTO_MSB = 55;
   localparam int CSUM_MSB  = 47;

   typedef enum logic [1:0] {HDR0, HDR1, PAYLOAD, BYPASS} ttl_dec_state_t;

   // End-around carry; a second fold is never needed because a carry leaves at most 16'hFFFE
   function automatic logic [15:0] ones_add16(input logic [15:0] a, input logic [15:0] b);
      logic [16:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return sum[15:0] + {15'd0, sum[16]};
   endfunction

endpackage

// File: rtl/ipv4_ttl_decrement_csum.sv
// Incremental IPv4 header checksum patch for one changed 16-bit field: HC' = ~(~HC + ~m + m').
// The result register is refreshed every cycle; update_valid marks the cycle it belongs to a request.
module ipv4_checksum_update
   import ipv4_pkg::*;
(
   input  logic        clk,
   input  logic        areset_n,
   input  logic        update_req,
   input  logic [15:0] old_field,
   input  logic [15:0] new_field,
   input  logic [15:0] old_checksum,
   output logic        update_valid,
   output logic [15:0] new_ip_checksum
);

   logic        update_valid_d, update_valid_q;
   logic [15:0] csum_d, csum_q;

   always_comb begin
      update_valid_d = update_req;
      csum_d         = ~ones_add16(ones_add16(~old_checksum, ~old_field), new_field);
   end

   always_ff @(posedge clk or negedge areset_n) begin
      if (!areset_n) begin
         update_valid_q <= 1'b0;
         csum_q         <= 16'h0;
      end else begin
         update_valid_q <= update_valid_d;
         csum_q         <= csum_d;
      end
   end

   assign update_valid    = update_valid_q;
   assign new_ip_checksum = csum_q;

endmodule

// File: rtl/ipv4_ttl_decrement.sv
// Two-stage AXI-Stream stage that decrements the IPv4 TTL and patches the header checksum.
// Optional statistics counters are built when IPV4_TTL_DECREMENT_STATS_EN is defined.
//
// state   | meaning
// HDR0    | next accepted beat is header beat 0 (version/IHL)
// HDR1    | next accepted beat is header beat 1 (TTL/protocol/checksum)
// PAYLOAD | rest of an IPv4 packet, passed through
// BYPASS  | rest of a non-IPv4 or malformed packet, passed through
module ipv4_ttl_decrement
   import ipv4_pkg::*;
#(
   parameter logic [7:0] TTL_MIN = 8'd1
)(
   input  logic        clk,
   input  logic        areset_n,
   input  logic [63:0] s_axis_tdata,
   input  logic [7:0]  s_axis_tkeep,
   input  logic        s_axis_tlast,
   input  logic        s_axis_tvalid,
   output logic        s_axis_tready,
   output logic [63:0] m_axis_tdata,
   output logic [7:0]  m_axis_tkeep,
   output logic        m_axis_tlast,
   output logic        m_axis_tuser,
   output logic        m_axis_tvalid,
   input  logic        m_axis_tready
`ifdef IPV4_TTL_DECREMENT_STATS_EN
  ,output logic [31:0] stat_pkt_count,
   output logic [31:0] stat_expired_count
`endif
);

   ttl_dec_state_t state_d, state_q;
   logic        exp_flag_d, exp_flag_q;

   logic        s1_valid_d, s1_valid_q;
   logic [63:0] s1_data_d, s1_data_q;
   logic [7:0]  s1_keep_d, s1_keep_q;
   logic        s1_last_d, s1_last_q;
   logic        s1_user_d, s1_user_q;
   logic        s1_rw_d, s1_rw_q;

   logic        m_valid_d, m_valid_q;
   logic [63:0] m_data_d, m_data_q;
   logic [7:0]  m_keep_d, m_keep_q;
   logic        m_last_d, m_last_q;
   logic        m_user_d, m_user_q;

   logic [15:0] csum_hold_d, csum_hold_q;
   logic        csum_hold_valid_d, csum_hold_valid_q;

   logic        ce, accept, is_ipv4, hdr1_full, ttl_live, expire_now;
   logic        update_req, update_valid;
   logic [7:0]  in_ttl;
   logic [15:0] new_ip_checksum, csum_sel;
   logic [63:0] beat_out;

   assign ce            = !m_valid_q || m_axis_tready;
   assign accept        = ce && s_axis_tvalid;
   assign s_axis_tready = ce;

   assign in_ttl     = s_axis_tdata[TTL_MSB -: 8];
   assign is_ipv4    = (s_axis_tdata[63:60] == IPV4_VERSION) && (s_axis_tdata[59:56] >= IPV4_IHL_MIN);
   // A beat 1 without bytes 8-11 carries no usable TTL/checksum and is left alone
   assign hdr1_full  = (s_axis_tkeep[7:4] == 4'hF);
   assign ttl_live   = in_ttl > TTL_MIN;
   assign expire_now = (state_q == HDR1) && hdr1_full && !ttl_live;
   assign update_req = accept && (state_q == HDR1) && hdr1_full && ttl_live;

   ipv4_checksum_update u_csum (
      .clk             (clk),
      .areset_n        (areset_n),
      .update_req      (update_req),
      .old_field       (s_axis_tdata[TTL_MSB -: 16]),
      .new_field       ({in_ttl - 8'd1, s_axis_tdata[PROTO_MSB -: 8]}),
      .old_checksum    (s_axis_tdata[CSUM_MSB -: 16]),
      .update_valid    (update_valid),
      .new_ip_checksum (new_ip_checksum)
   );

   always_comb begin
      state_d    = state_q;
      exp_flag_d = exp_flag_q;
      if (accept) begin
         case (state_q)
            HDR0: begin
               if (!s_axis_tlast) state_d = is_ipv4 ? HDR1 : BYPASS;
            end
            HDR1: begin
               if (expire_now) exp_flag_d = 1'b1;
               state_d = s_axis_tlast ? HDR0 : PAYLOAD;
            end
            PAYLOAD, BYPASS: begin
               if (s_axis_tlast) state_d = HDR0;
            end
            default: state_d = HDR0;
         endcase
         if (s_axis_tlast) exp_flag_d = 1'b0;
      end
   end

   // The updater result is only valid for one cycle; park it if beat 1 cannot move on
   always_comb begin
      csum_sel = (update_valid || !csum_hold_valid_q) ? new_ip_checksum : csum_hold_q;
      beat_out = s1_data_q;
      if (s1_rw_q) begin
         beat_out[TTL_MSB -: 8]   = s1_data_q[TTL_MSB -: 8] - 8'd1;
         beat_out[CSUM_MSB -: 16] = csum_sel;
      end

      csum_hold_d       = csum_hold_q;
      csum_hold_valid_d = csum_hold_valid_q;
      if (update_valid && !ce) begin
         csum_hold_d       = new_ip_checksum;
         csum_hold_valid_d = 1'b1;
      end else if (ce && s1_valid_q && s1_rw_q) begin
         csum_hold_valid_d = 1'b0;
      end
   end

   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_data_d  = s1_data_q;
      s1_keep_d  = s1_keep_q;
      s1_last_d  = s1_last_q;
      s1_user_d  = s1_user_q;
      s1_rw_d    = s1_rw_q;
      m_valid_d  = m_valid_q;
      m_data_d   = m_data_q;
      m_keep_d   = m_keep_q;
      m_last_d   = m_last_q;
      m_user_d   = m_user_q;
      if (ce) begin
         s1_valid_d = s_axis_tvalid;
         s1_data_d  = s_axis_tdata;
         s1_keep_d  = s_axis_tkeep;
         s1_last_d  = s_axis_tlast;
         s1_user_d  = s_axis_tlast && (exp_flag_q || expire_now);
         s1_rw_d    = update_req;
         m_valid_d  = s1_valid_q;
         m_data_d   = beat_out;
         m_keep_d   = s1_keep_q;
         m_last_d   = s1_last_q;
         m_user_d   = s1_user_q;
      end
   end

   always_ff @(posedge clk or negedge areset_n) begin
      if (!areset_n) begin
         state_q           <= HDR0;
         exp_flag_q        <= 1'b0;
         s1_valid_q        <= 1'b0;
         s1_data_q         <= 64'h0;
         s1_keep_q         <= 8'h0;
         s1_last_q         <= 1'b0;
         s1_user_q         <= 1'b0;
         s1_rw_q           <= 1'b0;
         m_valid_q         <= 1'b0;
         m_data_q          <= 64'h0;
         m_keep_q          <= 8'h0;
         m_last_q          <= 1'b0;
         m_user_q          <= 1'b0;
         csum_hold_q       <= 16'h0;
         csum_hold_valid_q <= 1'b0;
      end else begin
         state_q           <= state_d;
         exp_flag_q        <= exp_flag_d;
         s1_valid_q        <= s1_valid_d;
         s1_data_q         <= s1_data_d;
         s1_keep_q         <= s1_keep_d;
         s1_last_q         <= s1_last_d;
         s1_user_q         <= s1_user_d;
         s1_rw_q           <= s1_rw_d;
         m_valid_q         <= m_valid_d;
         m_data_q          <= m_data_d;
         m_keep_q          <= m_keep_d;
         m_last_q          <= m_last_d;
         m_user_q          <= m_user_d;
         csum_hold_q       <= csum_hold_d;
         csum_hold_valid_q <= csum_hold_valid_d;
      end
   end

   assign m_axis_tvalid = m_valid_q;
   assign m_axis_tdata  = m_data_q;
   assign m_axis_tkeep  = m_keep_q;
   assign m_axis_tlast  = m_last_q;
   assign m_axis_tuser  = m_user_q;

`ifdef IPV4_TTL_DECREMENT_STATS_EN
   logic [31:0] stat_pkt_d, stat_pkt_q;
   logic [31:0] stat_exp_d, stat_exp_q;
   logic        out_eop;

   assign out_eop = m_valid_q && m_axis_tready && m_last_q;

   always_comb begin
      stat_pkt_d = stat_pkt_q;
      stat_exp_d = stat_exp_q;
      if (out_eop && (stat_pkt_q != '1)) stat_pkt_d = stat_pkt_q + 32'd1;
      if (out_eop && m_user_q && (stat_exp_q != '1)) stat_exp_d = stat_exp_q + 32'd1;
   end

   always_ff @(posedge clk or negedge areset_n) begin
      if (!areset_n) begin
         stat_pkt_q <= 32'h0;
         stat_exp_q <= 32'h0;
      end else begin
         stat_pkt_q <= stat_pkt_d;
         stat_exp_q <= stat_exp_d;
      end
   end

   assign stat_pkt_count     = stat_pkt_q;
   assign stat_expired_count = stat_exp_q;
`endif

endmodule

// File: tb/tb_ipv4_ttl_decrement.sv
// Self-checking bench for ipv4_ttl_decrement: directed vector table, stall/reset sequences,
// and a randomized packet stream compared against a full-recompute header model.
`timescale 1ns/1ps
module tb_ipv4_ttl_decrement;

   localparam logic [7:0] TTL_MIN = 8'd1;

   logic        clk = 1'b0;
   logic        areset_n;
   logic [63:0] s_axis_tdata;
   logic [7:0]  s_axis_tkeep;
   logic        s_axis_tlast;
   logic        s_axis_tvalid;
   logic        s_axis_tready;
   logic [63:0] m_axis_tdata;
   logic [7:0]  m_axis_tkeep;
   logic        m_axis_tlast;
   logic        m_axis_tuser;
   logic        m_axis_tvalid;
   logic        m_axis_tready;
`ifdef IPV4_TTL_DECREMENT_STATS_EN
   logic [31:0] stat_pkt_count;
   logic [31:0] stat_expired_count;
`endif

   always #5 clk = ~clk;

   ipv4_ttl_decrement #(.TTL_MIN(TTL_MIN)) dut (
      .clk           (clk),
      .areset_n      (areset_n),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tkeep  (s_axis_tkeep),
      .s_axis_tlast  (s_axis_tlast),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tready (s_axis_tready),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tkeep  (m_axis_tkeep),
      .m_axis_tlast  (m_axis_tlast),
      .m_axis_tuser  (m_axis_tuser),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready)
`ifdef IPV4_TTL_DECREMENT_STATS_EN
     ,.stat_pkt_count     (stat_pkt_count),
      .stat_expired_count (stat_expired_count)
`endif
   );

   typedef struct packed {logic [63:0] d; logic [7:0] k; logic l;} beat_t;
   typedef struct packed {logic [63:0] d; logic [7:0] k; logic l; logic u;} obeat_t;
   typedef struct packed {
      logic [2:0]  n;
      logic [63:0] b0;
      logic [63:0] b1;
      logic [7:0]  k1;
      logic [63:0] b2;
      logic [63:0] e1;
      logic        eu;
   } vec_t;

   beat_t  in_q[$];
   obeat_t exp_q[$];
   vec_t   vecs[10];

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int in_idx = 0;
   int out_idx = 0;
   int lat_in = -1;
   int lat_out = -1;
   int stall_cnt = 0;
   bit stall_arm = 0;
   bit rnd_ready = 0;
   bit csum_verify = 0;
   logic [63:0] out_hdr[3];

   logic [63:0] g_d[5];
   logic [7:0]  g_k[5];
   int          g_n;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   // Folded one's-complement sum of the 20-byte header spread over beats 0..2
   function automatic logic [15:0] ocsum(input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
      logic [31:0] s;
      s = 32'(a[63:48]) + 32'(a[47:32]) + 32'(a[31:16]) + 32'(a[15:0])
        + 32'(b[63:48]) + 32'(b[47:32]) + 32'(b[31:16]) + 32'(b[15:0])
        + 32'(c[63:48]) + 32'(c[47:32]);
      while (s[31:16] != 16'h0) s = 32'(s[15:0]) + 32'(s[31:16]);
      return s[15:0];
   endfunction

   task automatic push_beat(input logic [63:0] d, input logic [7:0] k, input logic l,
                            input logic [63:0] ed, input logic eu);
      beat_t  b;
      obeat_t e;
      b.d = d;  b.k = k; b.l = l;
      e.d = ed; e.k = k; e.l = l; e.u = eu;
      in_q.push_back(b);
      exp_q.push_back(e);
   endtask

   task automatic push_vec(input vec_t v);
      logic [63:0] d;
      logic [7:0]  k;
      for (int i = 0; i < int'(v.n); i++) begin
         d = (i == 0) ? v.b0 : (i == 1) ? v.b1 : v.b2;
         k = (i == 1) ? v.k1 : (i == 2) ? 8'hF0 : 8'hFF;
         push_beat(d, k, i == int'(v.n) - 1, (i == 1) ? v.e1 : d, (i == int'(v.n) - 1) && v.eu);
      end
   endtask

   task automatic gen_pkt(input logic [7:0] ttl, input logic [3:0] ver, input int n);
      logic [7:0] klist[3];
      klist[0] = 8'hFF; klist[1] = 8'hF0; klist[2] = 8'h80;
      g_n = n;
      for (int i = 0; i < 5; i++) begin
         g_d[i] = {$urandom, $urandom};
         g_k[i] = 8'hFF;
      end
      g_d[0][63:56] = {ver, 4'd5};
      g_d[1][63:56] = ttl;
      g_d[1][47:32] = 16'h0;
      g_d[1][47:32] = ~ocsum(g_d[0], g_d[1], g_d[2]);
      if (n >= 3) g_k[n-1] = klist[$urandom_range(0, 2)];
   endtask

   // Reference: a live IPv4 header leaves with TTL-1 and a freshly computed header checksum
   task automatic model_push();
      logic [63:0] o1;
      logic        expired;
      o1      = g_d[1];
      expired = 1'b0;
      if (g_n >= 2 && g_d[0][63:60] == 4'd4 && g_d[0][59:56] >= 4'd5 && g_k[1][7:4] == 4'hF) begin
         if (g_d[1][63:56] <= TTL_MIN) begin
            expired = 1'b1;
         end else begin
            o1[63:56] = g_d[1][63:56] - 8'd1;
            o1[47:32] = 16'h0;
            o1[47:32] = ~ocsum(g_d[0], o1, g_d[2]);
         end
      end
      for (int i = 0; i < g_n; i++)
         push_beat(g_d[i], g_k[i], i == g_n - 1, (i == 1) ? o1 : g_d[i], (i == g_n - 1) && expired);
   endtask

   task automatic step();
      bit     forced;
      beat_t  b;
      obeat_t e;
      forced = 0;
      @(negedge clk);
      if (stall_cnt > 0) begin
         m_axis_tready = 1'b0;
         stall_cnt--;
         forced = 1;
      end else if (rnd_ready) begin
         m_axis_tready = 1'($urandom_range(0, 1));
      end else begin
         m_axis_tready = 1'b1;
      end
      if (in_q.size() > 0) begin
         b = in_q[0];
         s_axis_tvalid = 1'b1;
         s_axis_tdata  = b.d;
         s_axis_tkeep  = b.k;
         s_axis_tlast  = b.l;
      end else begin
         s_axis_tvalid = 1'b0;
      end
      #1;
      if (forced) check("stall_s_tready", 64'(s_axis_tready), 64'd0);
      if (s_axis_tvalid && s_axis_tready) begin
         if (in_idx == 0 && lat_in < 0) lat_in = cyc;
         if (stall_arm && in_idx == 1) begin
            stall_cnt = 3;
            stall_arm = 0;
         end
         in_idx = in_q[0].l ? 0 : in_idx + 1;
         void'(in_q.pop_front());
      end
      if (m_axis_tvalid && m_axis_tready) begin
         if (out_idx == 0 && lat_out < 0) lat_out = cyc;
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL extra_beat: got %h, want no beat", m_axis_tdata);
         end else begin
            e = exp_q.pop_front();
            check("tdata", m_axis_tdata, e.d);
            check("tkeep", 64'(m_axis_tkeep), 64'(e.k));
            check("tlast", 64'(m_axis_tlast), 64'(e.l));
            if (e.l) check("tuser", 64'(m_axis_tuser), 64'(e.u));
         end
         if (out_idx < 3) out_hdr[out_idx] = m_axis_tdata;
         if (m_axis_tlast) begin
            if (csum_verify && out_idx >= 2 && out_hdr[0][63:60] == 4'd4)
               check("hdr_csum", 64'(ocsum(out_hdr[0], out_hdr[1], out_hdr[2])), 64'hFFFF);
            out_idx = 0;
         end else begin
            out_idx++;
         end
      end
   endtask

   task automatic drain(input int budget);
      int c;
      c = 0;
      while ((in_q.size() > 0 || exp_q.size() > 0) && c < budget) begin
         step();
         c++;
      end
      if (c >= budget) begin
         tests++;
         fails++;
         $display("FAIL drain_timeout: got %0d beats pending, want 0", exp_q.size());
         in_q.delete();
         exp_q.delete();
      end else begin
         repeat (4) step();
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_tvalid"}, 64'(m_axis_tvalid), 64'd0);
      check({tag, "_tdata"},  m_axis_tdata,       64'd0);
      check({tag, "_tkeep"},  64'(m_axis_tkeep),  64'd0);
      check({tag, "_tlast"},  64'(m_axis_tlast),  64'd0);
      check({tag, "_tuser"},  64'(m_axis_tuser),  64'd0);
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog: got no finish, want finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int guard;
      vecs[0] = '{n:3'd3, b0:64'h4500_0073_0000_4000, b1:64'h4011_B861_C0A8_0001, k1:8'hFF,
                  b2:64'hC0A8_00C7_0000_0000, e1:64'h3F11_B961_C0A8_0001, eu:1'b0};
      vecs[1] = '{n:3'd3, b0:64'h4500_0073_0000_4000, b1:64'h0111_B961_C0A8_0001, k1:8'hFF,
                  b2:64'hC0A8_00C7_0000_0000, e1:64'h0111_B961_C0A8_0001, eu:1'b1};
      vecs[2] = '{n:3'd3, b0:64'h6000_0000_0011_4000, b1:64'h4011_B861_C0A8_0001, k1:8'hFF,
                  b2:64'hC0A8_00C7_0000_0000, e1:64'h4011_B861_C0A8_0001, eu:1'b0};
      vecs[3] = '{n:3'd1, b0:64'h4500_0073_0000_4000, b1:64'h0, k1:8'hFF,
                  b2:64'h0, e1:64'h0, eu:1'b0};
      vecs[4] = '{n:3'd2, b0:64'h4500_0073_0000_4000, b1:64'h0011_B861_C0A8_0001, k1:8'hFF,
                  b2:64'h0, e1:64'h0011_B861_C0A8_0001, eu:1'b1};
      vecs[5] = '{n:3'd3, b0:64'h4500_0073_0000_4000, b1:64'h4011_B861_C0A8_0001, k1:8'h0F,
                  b2:64'hC0A8_00C7_0000_0000, e1:64'h4011_B861_C0A8_0001, eu:1'b0};
      vecs[6] = '{n:3'd3, b0:64'h4400_0073_0000_4000, b1:64'h4011_B861_C0A8_0001, k1:8'hFF,
                  b2:64'hC0A8_00C7_0000_0000, e1:64'h4011_B861_C0A8_0001, eu:1'b0};
      vecs[7] = '{n:3'd3, b0:64'h4500_0073_0000_4000, b1:64'h0211_F661_C0A8_0001, k1:8'hFF,
                  b2:64'hC0A8_00C7_0000_0000, e1:64'h0111_F761_C0A8_0001, eu:1'b0};
      vecs[8] = '{n:3'd3, b0:64'h4500_0073_0000_4000, b1:64'hFF11_F960_C0A8_0001, k1:8'hFF,
                  b2:64'hC0A8_00C7_0000_0000, e1:64'hFE11_FA60_C0A8_0001, eu:1'b0};
      vecs[9] = '{n:3'd2, b0:64'h4500_0073_0000_4000, b1:64'h4011_B861_C0A8_0001, k1:8'hFF,
                  b2:64'h0, e1:64'h3F11_B961_C0A8_0001, eu:1'b0};

      areset_n      = 1'b0;
      s_axis_tvalid = 1'b0;
      s_axis_tdata  = 64'h0;
      s_axis_tkeep  = 8'h0;
      s_axis_tlast  = 1'b0;
      m_axis_tready = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      check_reset_outputs("reset");
      @(negedge clk);
      areset_n = 1'b1;

      for (int i = 0; i < 10; i++) begin
         push_vec(vecs[i]);
         drain(200);
         if (i == 0) check("latency", 64'(lat_out - lat_in), 64'd2);
      end

      stall_arm = 1;
      push_vec(vecs[0]);
      drain(200);
      check("stall_seen", 64'(stall_arm), 64'd0);

      rnd_ready   = 1;
      csum_verify = 1;
      for (int p = 0; p < 1000; p++) begin
         logic [7:0] ttls[4];
         ttls[0] = 8'h00; ttls[1] = 8'h01; ttls[2] = 8'h02; ttls[3] = 8'hFF;
         gen_pkt(ttls[$urandom_range(0, 3)], ($urandom_range(0, 9) == 0) ? 4'd6 : 4'd4,
                 int'($urandom_range(1, 5)));
         model_push();
      end
      drain(60000);
      rnd_ready   = 0;
      csum_verify = 0;

      gen_pkt(8'h40, 4'd4, 4);
      model_push();
      guard = 0;
      while (in_idx != 3 && guard < 50) begin
         step();
         guard++;
      end
      check("reset_reach_beat2", 64'(in_idx), 64'd3);
      @(posedge clk);
      #2;
      areset_n = 1'b0;
      #1;
      check_reset_outputs("midreset");
      in_q.delete();
      exp_q.delete();
      in_idx        = 0;
      out_idx       = 0;
      s_axis_tvalid = 1'b0;
      repeat (2) @(negedge clk);
      areset_n = 1'b1;
      push_vec(vecs[0]);
      drain(200);
      push_vec(vecs[7]);
      drain(200);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
